// File: rtl/id_ex_operand_stage_pkg.sv
// Shared RISC-V pipeline definitions: widths, ALU codes, operand-source encodings
// and the ID/EX register layout.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int RADDR_W   = 5;
    localparam int ALUCODE_W = 4;

    localparam logic [ALUCODE_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUCODE_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUCODE_W-1:0] ALU_SLTU = 4'd10;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic [RADDR_W-1:0]   rs1_addr;
        logic [RADDR_W-1:0]   rs2_addr;
        logic [RADDR_W-1:0]   rd;
        logic [ALUCODE_W-1:0] alu_code;
        logic [1:0]           src_a;
        logic [1:0]           src_b;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
    } id_ex_t;

    // A bubble only needs its side-effecting controls cleared; datapath fields are don't-care.
    function automatic id_ex_t bubble(input id_ex_t e);
        id_ex_t b;
        b           = e;
        b.valid     = 1'b0;
        b.reg_write = 1'b0;
        b.mem_read  = 1'b0;
        b.mem_write = 1'b0;
        b.alu_code  = ALU_ADD;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-stage inputs, bypass sources, pipeline control and EX outputs
// around the ID/EX operand stage.
interface id_ex_operand_stage_if;
    import riscv_pkg::*;

    logic                 id_valid;
    logic [XLEN-1:0]      id_pc;
    logic [XLEN-1:0]      id_rs1_data;
    logic [XLEN-1:0]      id_rs2_data;
    logic [XLEN-1:0]      id_imm;
    logic [RADDR_W-1:0]   id_rs1_addr;
    logic [RADDR_W-1:0]   id_rs2_addr;
    logic [RADDR_W-1:0]   id_rd_addr;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [ALUCODE_W-1:0] id_alu_code;
    logic [1:0]           id_src_a;
    logic [1:0]           id_src_b;
    logic                 id_reg_write;
    logic                 id_mem_read;
    logic                 id_mem_write;
    logic                 hold;
    logic                 flush;
    logic                 exmem_reg_write;
    logic [RADDR_W-1:0]   exmem_rd;
    logic [XLEN-1:0]      exmem_result;
    logic                 memwb_reg_write;
    logic [RADDR_W-1:0]   memwb_rd;
    logic [XLEN-1:0]      memwb_wdata;
    logic [XLEN-1:0]      alu_a;
    logic [XLEN-1:0]      alu_b;
    logic [ALUCODE_W-1:0] alu_code;
    logic [XLEN-1:0]      ex_store_data;
    logic [XLEN-1:0]      ex_pc;
    logic [RADDR_W-1:0]   ex_rd;
    logic                 ex_valid;
    logic                 ex_reg_write;
    logic                 ex_mem_read;
    logic                 ex_mem_write;
    logic                 load_use_stall;

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_uses_rs1, id_uses_rs2,
               id_alu_code, id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write,
               hold, flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_wdata,
        output alu_a, alu_b, alu_code, ex_store_data, ex_pc, ex_rd, ex_valid,
               ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_uses_rs1, id_uses_rs2,
               id_alu_code, id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write,
               hold, flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_wdata,
        input  alu_a, alu_b, alu_code, ex_store_data, ex_pc, ex_rd, ex_valid,
               ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand bypass select: EX/MEM beats MEM/WB beats the registered regfile value;
// x0 is never bypassed.
module fwd_mux
    import riscv_pkg::*;
(
    input  logic [RADDR_W-1:0] rs_addr_i,
    input  logic [XLEN-1:0]    rf_data_i,
    input  logic               exmem_reg_write_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]    exmem_result_i,
    input  logic               memwb_reg_write_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]    memwb_wdata_i,
    output logic [XLEN-1:0]    fwd_data_o
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_i);
    assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_i);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch can be inferred.
        fwd_data_o = rf_data_i;
        if (exmem_hit)      fwd_data_o = exmem_result_i;
        else if (memwb_hit) fwd_data_o = memwb_wdata_i;
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus operand delivery to the ALU: bypassing, source
// selection and load-use hazard detection.
module id_ex_operand_stage
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    id_ex_operand_stage_if.slave bus
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    id_ex_t          id_fields;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            load_use;

    fwd_mux u_fwd_rs1 (
        .rs_addr_i         (ex_q.rs1_addr),
        .rf_data_i         (ex_q.rs1_data),
        .exmem_reg_write_i (bus.exmem_reg_write),
        .exmem_rd_i        (bus.exmem_rd),
        .exmem_result_i    (bus.exmem_result),
        .memwb_reg_write_i (bus.memwb_reg_write),
        .memwb_rd_i        (bus.memwb_rd),
        .memwb_wdata_i     (bus.memwb_wdata),
        .fwd_data_o        (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs_addr_i         (ex_q.rs2_addr),
        .rf_data_i         (ex_q.rs2_data),
        .exmem_reg_write_i (bus.exmem_reg_write),
        .exmem_rd_i        (bus.exmem_rd),
        .exmem_result_i    (bus.exmem_result),
        .memwb_reg_write_i (bus.memwb_reg_write),
        .memwb_rd_i        (bus.memwb_rd),
        .memwb_wdata_i     (bus.memwb_wdata),
        .fwd_data_o        (fwd_rs2)
    );

    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid &&
                      ((bus.id_uses_rs1 && (bus.id_rs1_addr == ex_q.rd)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2_addr == ex_q.rd)));

    always_comb begin
        id_fields           = '0;
        id_fields.valid     = bus.id_valid;
        id_fields.pc        = bus.id_pc;
        id_fields.rs1_data  = bus.id_rs1_data;
        id_fields.rs2_data  = bus.id_rs2_data;
        id_fields.imm       = bus.id_imm;
        id_fields.rs1_addr  = bus.id_rs1_addr;
        id_fields.rs2_addr  = bus.id_rs2_addr;
        id_fields.rd        = bus.id_rd_addr;
        id_fields.alu_code  = bus.id_alu_code;
        id_fields.src_a     = bus.id_src_a;
        id_fields.src_b     = bus.id_src_b;
        id_fields.reg_write = bus.id_reg_write;
        id_fields.mem_read  = bus.id_mem_read;
        id_fields.mem_write = bus.id_mem_write;
    end

    // While held, re-capture the bypassed operands so they survive the producer retiring.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = bubble(ex_q);
        end else if (bus.hold) begin
            ex_d.rs1_data = fwd_rs1;
            ex_d.rs2_data = fwd_rs2;
        end else if (load_use) begin
            ex_d = bubble(ex_q);
        end else if (!bus.id_valid) begin
            ex_d = bubble(id_fields);
        end else begin
            ex_d = id_fields;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    always_comb begin
        bus.alu_a = '0;
        case (ex_q.src_a)
            SRC_A_RS1:  bus.alu_a = fwd_rs1;
            SRC_A_PC:   bus.alu_a = ex_q.pc;
            SRC_A_ZERO: bus.alu_a = '0;
            default:    bus.alu_a = '0;
        endcase
    end

    always_comb begin
        bus.alu_b = '0;
        case (ex_q.src_b)
            SRC_B_RS2:  bus.alu_b = fwd_rs2;
            SRC_B_IMM:  bus.alu_b = ex_q.imm;
            SRC_B_FOUR: bus.alu_b = XLEN'(4);
            default:    bus.alu_b = '0;
        endcase
    end

    assign bus.alu_code       = ex_q.alu_code;
    assign bus.ex_store_data  = fwd_rs2;
    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_rd          = ex_q.rd;
    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.load_use_stall = load_use;

endmodule
